// File: rtl/offnariscv_pkg.sv
// Shared ACE widths and read-arbiter types for the offnariscv core.
package offnariscv_pkg;

    localparam int ACE_XID_WIDTH     = 4;
    localparam int ACE_AXLEN_WIDTH   = 8;
    localparam int ACE_AXSIZE_WIDTH  = 3;
    localparam int ACE_AXBURST_WIDTH = 2;
    localparam int ACE_ARSNOOP_WIDTH = 4;
    localparam int ACE_DOMAIN_WIDTH  = 2;
    localparam int ACE_RRESP_WIDTH   = 4;

    // Address width of the AR holding register; matches the default
    // ACE_AXADDR_WIDTH parameter of ace_rd_arbiter.
    localparam int RDARB_ADDR_WIDTH = 32;
    localparam int RDARB_NUM_REQ    = 2;

    typedef struct packed {
        logic [RDARB_ADDR_WIDTH-1:0]  addr;
        logic [ACE_AXLEN_WIDTH-1:0]   len;
        logic [ACE_AXSIZE_WIDTH-1:0]  size;
        logic [ACE_AXBURST_WIDTH-1:0] burst;
        logic [ACE_ARSNOOP_WIDTH-1:0] snoop;
        logic [ACE_DOMAIN_WIDTH-1:0]  domain;
    } rdarb_ar_t;

    typedef enum logic {
        RDARB_IDLE  = 1'b0,
        RDARB_ISSUE = 1'b1
    } rdarb_state_t;

    // ARID carries the requester index, zero-extended.
    function automatic logic [ACE_XID_WIDTH-1:0] rdarb_arid(input logic idx);
        return {{(ACE_XID_WIDTH-1){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/ace_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the requester that did not win last
// time is chosen; the history only advances when upd is asserted.
module rr_arb2
    import offnariscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    logic last_grant_p1;

    // Remember the most recent winner; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_p1 <= 1'b1;
        end else if (upd) begin
            last_grant_p1 <= gnt_idx;
        end
    end

    // Pick a winner among the active requests.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant_p1;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
        gnt = gnt_vld ? (2'b01 << gnt_idx) : 2'b00;
    end

endmodule

// File: rtl/ace_rd_arbiter.sv
// Shares one ACE read path between instruction fetch (port 0) and load/store
// (port 1). AR is arbitrated round-robin and tagged with the requester index
// in ARID; R beats are steered back by ID[0]; RACK is generated here.
module ace_rd_arbiter
    import offnariscv_pkg::*;
#(
    parameter int ACE_XDATA_WIDTH  = 256,
    parameter int ACE_AXADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [ACE_AXADDR_WIDTH-1:0]  s0_araddr,
    input  logic [ACE_AXLEN_WIDTH-1:0]   s0_arlen,
    input  logic [ACE_AXSIZE_WIDTH-1:0]  s0_arsize,
    input  logic [ACE_AXBURST_WIDTH-1:0] s0_arburst,
    input  logic [ACE_ARSNOOP_WIDTH-1:0] s0_arsnoop,
    input  logic [ACE_DOMAIN_WIDTH-1:0]  s0_ardomain,
    input  logic                         s0_arvalid,
    output logic                         s0_arready,
    output logic [ACE_XDATA_WIDTH-1:0]   s0_rdata,
    output logic [ACE_RRESP_WIDTH-1:0]   s0_rresp,
    output logic                         s0_rlast,
    output logic                         s0_rvalid,
    input  logic                         s0_rready,

    input  logic [ACE_AXADDR_WIDTH-1:0]  s1_araddr,
    input  logic [ACE_AXLEN_WIDTH-1:0]   s1_arlen,
    input  logic [ACE_AXSIZE_WIDTH-1:0]  s1_arsize,
    input  logic [ACE_AXBURST_WIDTH-1:0] s1_arburst,
    input  logic [ACE_ARSNOOP_WIDTH-1:0] s1_arsnoop,
    input  logic [ACE_DOMAIN_WIDTH-1:0]  s1_ardomain,
    input  logic                         s1_arvalid,
    output logic                         s1_arready,
    output logic [ACE_XDATA_WIDTH-1:0]   s1_rdata,
    output logic [ACE_RRESP_WIDTH-1:0]   s1_rresp,
    output logic                         s1_rlast,
    output logic                         s1_rvalid,
    input  logic                         s1_rready,

    output logic [ACE_XID_WIDTH-1:0]     m_arid,
    output logic [ACE_AXADDR_WIDTH-1:0]  m_araddr,
    output logic [ACE_AXLEN_WIDTH-1:0]   m_arlen,
    output logic [ACE_AXSIZE_WIDTH-1:0]  m_arsize,
    output logic [ACE_AXBURST_WIDTH-1:0] m_arburst,
    output logic [ACE_ARSNOOP_WIDTH-1:0] m_arsnoop,
    output logic [ACE_DOMAIN_WIDTH-1:0]  m_ardomain,
    output logic                         m_arvalid,
    input  logic                         m_arready,

    input  logic [ACE_XID_WIDTH-1:0]     m_rid,
    input  logic [ACE_XDATA_WIDTH-1:0]   m_rdata,
    input  logic [ACE_RRESP_WIDTH-1:0]   m_rresp,
    input  logic                         m_rlast,
    input  logic                         m_rvalid,
    output logic                         m_rready,

    output logic                         m_rack,
    output logic                         err_unexp_rid
);

    rdarb_state_t                   state_p1;
    rdarb_state_t                   state_nxt;
    logic [RDARB_NUM_REQ-1:0]       busy_p1;
    rdarb_ar_t [RDARB_NUM_REQ-1:0]  ar_req;
    rdarb_ar_t                      ar_p1;
    logic [ACE_XID_WIDTH-1:0]       arid_p1;
    logic                           rack_p1;
    logic                           err_p1;

    logic [RDARB_NUM_REQ-1:0]       arb_req;
    logic [RDARB_NUM_REQ-1:0]       gnt;
    logic                           gnt_idx;
    logic                           gnt_vld;

    logic                           r_idx;
    logic                           r_hit;
    logic                           r_last_hs;
    logic [RDARB_NUM_REQ-1:0]       r_clr;
    logic                           unused_rid_hi;

    // Requester payloads gathered into one indexable vector.
    always_comb begin
        ar_req[0].addr   = s0_araddr;
        ar_req[0].len    = s0_arlen;
        ar_req[0].size   = s0_arsize;
        ar_req[0].burst  = s0_arburst;
        ar_req[0].snoop  = s0_arsnoop;
        ar_req[0].domain = s0_ardomain;
        ar_req[1].addr   = s1_araddr;
        ar_req[1].len    = s1_arlen;
        ar_req[1].size   = s1_arsize;
        ar_req[1].burst  = s1_arburst;
        ar_req[1].snoop  = s1_arsnoop;
        ar_req[1].domain = s1_ardomain;
    end

    // Only idle requesters compete, and only while the AR slot is free.
    always_comb begin
        arb_req = 2'b00;
        if (state_p1 == RDARB_IDLE) begin
            arb_req = {s1_arvalid & ~busy_p1[1], s0_arvalid & ~busy_p1[0]};
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .upd     (gnt_vld),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign s0_arready = gnt[0];
    assign s1_arready = gnt[1];

    // AR FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= RDARB_IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // AR FSM next state: grant moves to ISSUE, downstream accept returns to IDLE.
    always_comb begin
        state_nxt = state_p1;
        m_arvalid = 1'b0;
        case (state_p1)
            RDARB_IDLE: begin
                if (gnt_vld) begin
                    state_nxt = RDARB_ISSUE;
                end
            end
            RDARB_ISSUE: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_nxt = RDARB_IDLE;
                end
            end
            default: state_nxt = RDARB_IDLE;
        endcase
    end

    // Capture the winner's payload; held unchanged while ISSUE waits for m_arready.
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_p1   <= '0;
            arid_p1 <= '0;
        end else if (gnt_vld) begin
            ar_p1   <= ar_req[gnt_idx];
            arid_p1 <= rdarb_arid(gnt_idx);
        end
    end

    assign m_arid     = arid_p1;
    assign m_araddr   = ar_p1.addr;
    assign m_arlen    = ar_p1.len;
    assign m_arsize   = ar_p1.size;
    assign m_arburst  = ar_p1.burst;
    assign m_arsnoop  = ar_p1.snoop;
    assign m_ardomain = ar_p1.domain;

    // R steering: ID bit 0 selects the requester; beats for idle IDs are sunk.
    always_comb begin
        r_idx     = m_rid[0];
        r_hit     = busy_p1[r_idx];
        s0_rvalid = m_rvalid & r_hit & ~r_idx;
        s1_rvalid = m_rvalid & r_hit & r_idx;
        m_rready  = r_hit ? (r_idx ? s1_rready : s0_rready) : m_rvalid;
        r_last_hs = m_rvalid & m_rready & m_rlast & r_hit;
        r_clr     = r_last_hs ? (2'b01 << r_idx) : 2'b00;
    end

    assign s0_rdata      = m_rdata;
    assign s0_rresp      = m_rresp;
    assign s0_rlast      = m_rlast;
    assign s1_rdata      = m_rdata;
    assign s1_rresp      = m_rresp;
    assign s1_rlast      = m_rlast;
    assign unused_rid_hi = ^m_rid[ACE_XID_WIDTH-1:1];

    // Outstanding-read tracking, RACK pulse and sticky unexpected-ID flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_p1 <= '0;
            rack_p1 <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            busy_p1 <= (busy_p1 | gnt) & ~r_clr;
            rack_p1 <= r_last_hs;
            if (m_rvalid && !r_hit) begin
                err_p1 <= 1'b1;
            end
        end
    end

    assign m_rack        = rack_p1;
    assign err_unexp_rid = err_p1;

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Scoreboard bench for ace_rd_arbiter: directed stimulus pushes expected AR,
// R and RACK events into queues; monitors pop and compare on DUT outputs.
module tb_ace_rd_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s0_araddr, s1_araddr;
    logic [7:0]   s0_arlen, s1_arlen;
    logic [2:0]   s0_arsize, s1_arsize;
    logic [1:0]   s0_arburst, s1_arburst;
    logic [3:0]   s0_arsnoop, s1_arsnoop;
    logic [1:0]   s0_ardomain, s1_ardomain;
    logic         s0_arvalid, s1_arvalid;
    logic         s0_arready, s1_arready;
    logic [255:0] s0_rdata, s1_rdata;
    logic [3:0]   s0_rresp, s1_rresp;
    logic         s0_rlast, s1_rlast;
    logic         s0_rvalid, s1_rvalid;
    logic         s0_rready, s1_rready;
    logic [3:0]   m_arid;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [3:0]   m_arsnoop;
    logic [1:0]   m_ardomain;
    logic         m_arvalid, m_arready;
    logic [3:0]   m_rid;
    logic [255:0] m_rdata;
    logic [3:0]   m_rresp;
    logic         m_rlast, m_rvalid, m_rready;
    logic         m_rack, err_unexp_rid;

    ace_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arsnoop(s0_arsnoop), .s0_ardomain(s0_ardomain),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arsnoop(s1_arsnoop), .s1_ardomain(s1_ardomain),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arsnoop(m_arsnoop), .m_ardomain(m_ardomain),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rack(m_rack), .err_unexp_rid(err_unexp_rid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_exp_t;

    typedef struct packed {
        logic [255:0] data;
        logic [3:0]   resp;
        logic         last;
    } r_exp_t;

    ar_exp_t exp_ar[$];
    r_exp_t  exp_r0[$];
    r_exp_t  exp_r1[$];
    int      exp_rack[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [255:0] mk(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // AR monitor: every downstream AR handshake must match the next expected request.
    always @(negedge clk) begin
        if (!rst && m_arvalid && m_arready) begin
            if (exp_ar.size() == 0) begin
                chk("ar_unexpected", {m_arid, m_araddr}, '0);
            end else begin
                ar_exp_t e;
                e = exp_ar.pop_front();
                chk("ar_id", m_arid, e.id);
                chk("ar_addr", m_araddr, e.addr);
                chk("ar_len", m_arlen, e.len);
                chk("ar_size", m_arsize, e.size);
            end
        end
    end

    // R monitor for port 0.
    always @(negedge clk) begin
        if (!rst && s0_rvalid && s0_rready) begin
            if (exp_r0.size() == 0) begin
                chk("r0_unexpected", s0_rdata, '0);
            end else begin
                r_exp_t e;
                e = exp_r0.pop_front();
                chk("r0_data", s0_rdata, e.data);
                chk("r0_resp", s0_rresp, e.resp);
                chk("r0_last", s0_rlast, e.last);
            end
        end
    end

    // R monitor for port 1.
    always @(negedge clk) begin
        if (!rst && s1_rvalid && s1_rready) begin
            if (exp_r1.size() == 0) begin
                chk("r1_unexpected", s1_rdata, '0);
            end else begin
                r_exp_t e;
                e = exp_r1.pop_front();
                chk("r1_data", s1_rdata, e.data);
                chk("r1_resp", s1_rresp, e.resp);
                chk("r1_last", s1_rlast, e.last);
            end
        end
    end

    // RACK monitor: each pulse must land in the cycle the stimulus predicted.
    always @(negedge clk) begin
        if (m_rack) begin
            if (exp_rack.size() == 0) begin
                chk("rack_unexpected", 256'(cyc), 256'(0));
            end else begin
                int e;
                e = exp_rack.pop_front();
                chk("rack_cycle", 256'(cyc), 256'(e));
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst = 1'b1;
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        s0_rready = 1'b1; s1_rready = 1'b1;
        tick; tick;
        rst = 1'b0;
    endtask

    // One R beat expected to complete this cycle; port < 0 means nobody should see it.
    task automatic r_beat(input logic [3:0] id, input logic [31:0] w, input logic last, input int port);
        r_exp_t e;
        m_rid = id; m_rdata = mk(w); m_rresp = w[3:0]; m_rlast = last; m_rvalid = 1'b1;
        e.data = mk(w); e.resp = w[3:0]; e.last = last;
        if (port == 0) exp_r0.push_back(e);
        if (port == 1) exp_r1.push_back(e);
        if (port >= 0 && last) exp_rack.push_back(cyc + 1);
        tick;
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    initial begin
        s0_araddr = '0; s0_arlen = '0; s0_arsize = 3'd5; s0_arburst = 2'd1;
        s0_arsnoop = '0; s0_ardomain = 2'd2;
        s1_araddr = '0; s1_arlen = '0; s1_arsize = 3'd6; s1_arburst = 2'd1;
        s1_arsnoop = 4'd1; s1_ardomain = 2'd2;
        m_rid = '0; m_rdata = '0; m_rresp = '0;
        do_reset;

        // Reset state.
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_m_araddr", m_araddr, 32'h0);
        chk("rst_m_arid", m_arid, 4'h0);
        chk("rst_m_rack", m_rack, 1'b0);
        chk("rst_err", err_unexp_rid, 1'b0);
        chk("rst_s0_arready", s0_arready, 1'b0);
        chk("rst_m_rready", m_rready, 1'b0);
        chk("rst_s0_rvalid", s0_rvalid, 1'b0);
        chk("rst_s1_rvalid", s1_rvalid, 1'b0);

        // Single fetch, two beats; first beat uses an upper ID bit that must be ignored.
        s0_araddr = 32'h8000_0000; s0_arlen = 8'd1; s0_arvalid = 1'b1;
        exp_ar.push_back('{id: 4'd0, addr: 32'h8000_0000, len: 8'd1, size: 3'd5});
        #1;
        chk("t1_s0_arready", s0_arready, 1'b1);
        chk("t1_s1_arready", s1_arready, 1'b0);
        tick;
        s0_arvalid = 1'b0; m_arready = 1'b1;
        chk("t1_m_arvalid", m_arvalid, 1'b1);
        tick;
        m_arready = 1'b0;
        chk("t1_idle_arvalid", m_arvalid, 1'b0);
        r_beat(4'h2, 32'h1111_1110, 1'b0, 0);
        r_beat(4'h0, 32'h2222_2221, 1'b1, 0);
        tick; tick;

        // Simultaneous requests from reset, then interleaved R beats.
        do_reset;
        s0_araddr = 32'h0000_1000; s0_arlen = 8'd0; s0_arvalid = 1'b1;
        s1_araddr = 32'h0000_2040; s1_arlen = 8'd3; s1_arvalid = 1'b1;
        m_arready = 1'b1;
        exp_ar.push_back('{id: 4'd0, addr: 32'h0000_1000, len: 8'd0, size: 3'd5});
        exp_ar.push_back('{id: 4'd1, addr: 32'h0000_2040, len: 8'd3, size: 3'd6});
        #1;
        chk("t2_s0_arready_t", s0_arready, 1'b1);
        chk("t2_s1_arready_t", s1_arready, 1'b0);
        tick;
        s0_arvalid = 1'b0;
        #1;
        chk("t2_s1_arready_t1", s1_arready, 1'b0);
        tick;
        chk("t2_s1_arready_t2", s1_arready, 1'b1);
        tick;
        s1_arvalid = 1'b0;
        tick;
        m_arready = 1'b0;
        r_beat(4'h1, 32'hA1A1_0002, 1'b0, 1);
        r_beat(4'h0, 32'hB0B0_0004, 1'b0, 0);
        r_beat(4'h1, 32'hA1A1_0003, 1'b1, 1);
        r_beat(4'h0, 32'hB0B0_0005, 1'b1, 0);
        tick; tick;

        // Busy blocking: a second s1 request waits for the first read's rlast.
        do_reset;
        s1_araddr = 32'h0000_3000; s1_arlen = 8'd0; s1_arvalid = 1'b1; m_arready = 1'b1;
        exp_ar.push_back('{id: 4'd1, addr: 32'h0000_3000, len: 8'd0, size: 3'd6});
        exp_ar.push_back('{id: 4'd1, addr: 32'h0000_3000, len: 8'd0, size: 3'd6});
        tick;
        tick;
        chk("t3_blocked_a", s1_arready, 1'b0);
        tick;
        chk("t3_blocked_b", s1_arready, 1'b0);
        m_rid = 4'h1; m_rdata = mk(32'h3333_0001); m_rresp = 4'h1; m_rlast = 1'b1; m_rvalid = 1'b1;
        exp_r1.push_back('{data: mk(32'h3333_0001), resp: 4'h1, last: 1'b1});
        exp_rack.push_back(cyc + 1);
        #1;
        chk("t3_blocked_at_rlast", s1_arready, 1'b0);
        tick;
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #1;
        chk("t3_regrant_t1", s1_arready, 1'b1);
        tick;
        s1_arvalid = 1'b0;
        tick;
        m_arready = 1'b0;
        r_beat(4'h1, 32'h3333_0002, 1'b1, 1);
        tick; tick;

        // AR and R backpressure.
        do_reset;
        s0_araddr = 32'hCAFE_0040; s0_arlen = 8'd3; s0_arvalid = 1'b1;
        exp_ar.push_back('{id: 4'd0, addr: 32'hCAFE_0040, len: 8'd3, size: 3'd5});
        tick;
        s0_arvalid = 1'b0; s0_araddr = 32'hDEAD_BEEF; s0_arlen = 8'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_m_arvalid", m_arvalid, 1'b1);
            chk("bp_m_araddr", m_araddr, 32'hCAFE_0040);
            chk("bp_m_arlen", m_arlen, 8'd3);
            tick;
        end
        m_arready = 1'b1;
        tick;
        m_arready = 1'b0;
        s0_rready = 1'b0;
        m_rid = 4'h0; m_rdata = mk(32'h4444_0006); m_rresp = 4'h6; m_rlast = 1'b1; m_rvalid = 1'b1;
        #1;
        chk("bp_m_rready_a", m_rready, 1'b0);
        chk("bp_s0_rvalid_a", s0_rvalid, 1'b1);
        tick;
        chk("bp_m_rready_b", m_rready, 1'b0);
        chk("bp_s0_rvalid_b", s0_rvalid, 1'b1);
        s0_rready = 1'b1;
        exp_r0.push_back('{data: mk(32'h4444_0006), resp: 4'h6, last: 1'b1});
        exp_rack.push_back(cyc + 1);
        tick;
        m_rvalid = 1'b0; m_rlast = 1'b0;
        tick; tick;

        // Unexpected ID: sunk, nobody sees it, sticky error.
        m_rid = 4'h1; m_rdata = mk(32'h5555_0000); m_rresp = 4'h0; m_rlast = 1'b1; m_rvalid = 1'b1;
        #1;
        chk("ux_m_rready", m_rready, 1'b1);
        chk("ux_s0_rvalid", s0_rvalid, 1'b0);
        chk("ux_s1_rvalid", s1_rvalid, 1'b0);
        chk("ux_err_before", err_unexp_rid, 1'b0);
        tick;
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("ux_err_set", err_unexp_rid, 1'b1);
        tick; tick;
        chk("ux_err_sticky", err_unexp_rid, 1'b1);

        // Reset while an AR is waiting in ISSUE.
        s0_araddr = 32'h0000_6000; s0_arvalid = 1'b1; m_arready = 1'b0;
        tick;
        s0_arvalid = 1'b0;
        chk("rs_issue_arvalid", m_arvalid, 1'b1);
        chk("rs_issue_araddr", m_araddr, 32'h0000_6000);
        rst = 1'b1;
        tick;
        chk("rs_arvalid_cleared", m_arvalid, 1'b0);
        chk("rs_araddr_cleared", m_araddr, 32'h0);
        chk("rs_err_cleared", err_unexp_rid, 1'b0);
        rst = 1'b0;
        tick; tick;

        chk("end_exp_ar_empty", 256'(exp_ar.size()), 256'(0));
        chk("end_exp_r0_empty", 256'(exp_r0.size()), 256'(0));
        chk("end_exp_r1_empty", 256'(exp_r1.size()), 256'(0));
        chk("end_exp_rack_empty", 256'(exp_rack.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
